// File: rtl/rrf_multiport.sv
// Multiport rename register file: N writeback ports, M bypassed read ports,
// multi-entry allocate/commit, global flush and a valid-entry popcount.
module rrf_multiport #(
    parameter int unsigned DATA_LEN  = 32,
    parameter int unsigned RRF_NUM   = 64,
    parameter int unsigned RRF_SEL   = 6,
    parameter int unsigned NUM_WB    = 5,
    parameter int unsigned NUM_RD    = 4,
    parameter int unsigned NUM_ALLOC = 2,
    parameter int unsigned NUM_COM   = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_RD*RRF_SEL-1:0]     rd_tag_i,
    output logic [NUM_RD*DATA_LEN-1:0]    rd_data_o,
    output logic [NUM_RD-1:0]             rd_valid_o,
    input  logic [NUM_WB-1:0]             wb_we_i,
    input  logic [NUM_WB*RRF_SEL-1:0]     wb_tag_i,
    input  logic [NUM_WB*DATA_LEN-1:0]    wb_data_i,
    input  logic [NUM_ALLOC-1:0]          alloc_en_i,
    input  logic [NUM_ALLOC*RRF_SEL-1:0]  alloc_tag_i,
    input  logic [NUM_COM*RRF_SEL-1:0]    com_tag_i,
    output logic [NUM_COM*DATA_LEN-1:0]   com_data_o,
    input  logic                          flush_i,
    output logic [RRF_SEL:0]              valid_cnt_o
);

    logic [RRF_NUM-1:0]  valid_q, valid_d;
    logic [DATA_LEN-1:0] data_q [RRF_NUM];
    logic [DATA_LEN-1:0] data_d [RRF_NUM];

    // Ascending port order makes the highest writeback port win on tag collisions.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (wb_we_i[k]) begin
                data_d[wb_tag_i[k*RRF_SEL +: RRF_SEL]]  = wb_data_i[k*DATA_LEN +: DATA_LEN];
                valid_d[wb_tag_i[k*RRF_SEL +: RRF_SEL]] = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_ALLOC; j++) begin
            if (alloc_en_i[j]) begin
                valid_d[alloc_tag_i[j*RRF_SEL +: RRF_SEL]] = 1'b0;
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < RRF_NUM; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // Same-cycle writeback bypass, ignoring alloc and flush.
    always_comb begin
        rd_data_o  = '0;
        rd_valid_o = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_data_o[p*DATA_LEN +: DATA_LEN] = data_q[rd_tag_i[p*RRF_SEL +: RRF_SEL]];
            rd_valid_o[p] = valid_q[rd_tag_i[p*RRF_SEL +: RRF_SEL]];
            for (int unsigned k = 0; k < NUM_WB; k++) begin
                if (wb_we_i[k] &&
                    (wb_tag_i[k*RRF_SEL +: RRF_SEL] == rd_tag_i[p*RRF_SEL +: RRF_SEL])) begin
                    rd_data_o[p*DATA_LEN +: DATA_LEN] = wb_data_i[k*DATA_LEN +: DATA_LEN];
                    rd_valid_o[p] = 1'b1;
                end
            end
            if (reset_i) begin
                rd_valid_o[p] = 1'b0;
            end
        end
    end

    always_comb begin
        com_data_o = '0;
        for (int unsigned c = 0; c < NUM_COM; c++) begin
            com_data_o[c*DATA_LEN +: DATA_LEN] = data_q[com_tag_i[c*RRF_SEL +: RRF_SEL]];
        end
    end

    always_comb begin
        valid_cnt_o = '0;
        for (int unsigned i = 0; i < RRF_NUM; i++) begin
            valid_cnt_o = valid_cnt_o + {{RRF_SEL{1'b0}}, valid_q[i]};
        end
    end

endmodule

// File: doc/rrf_multiport.md
Name: rrf_multiport

Overview:
Parametrised rename register file for the DP stage. It holds speculative results indexed by rrftag, with a valid bit per entry. Compared with the single-issue RRF, it has N writeback ports, M source read ports with same-cycle writeback bypass, multi-entry allocation, multi-entry commit readout, a global flush, and an occupancy counter. It sits between rename/dispatch (read, allocate), the execution units (writeback) and COM (commit copy to ARF).

Parameters:
DATA_LEN, 32, entry data width
RRF_NUM, 64, number of entries (power of two, ≥4)
RRF_SEL, 6, tag width = log2(RRF_NUM)
NUM_WB, 5, writeback ports (alu1, alu2, ldst, mul, branch order)
NUM_RD, 4, source read ports (2 instrs × rs1/rs2)
NUM_ALLOC, 2, allocate ports per cycle
NUM_COM, 2, commit read ports

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
rd_tag_i  in  NUM_RD*RRF_SEL  source tags, port k at [k*RRF_SEL +: RRF_SEL]
rd_data_o  out  NUM_RD*DATA_LEN  source data
rd_valid_o  out  NUM_RD  source valid
wb_we_i  in  NUM_WB  writeback enable per port
wb_tag_i  in  NUM_WB*RRF_SEL  writeback tags
wb_data_i  in  NUM_WB*DATA_LEN  writeback data
alloc_en_i  in  NUM_ALLOC  allocate enable
alloc_tag_i  in  NUM_ALLOC*RRF_SEL  allocated tags
com_tag_i  in  NUM_COM*RRF_SEL  committing tags
com_data_o  out  NUM_COM*DATA_LEN  data for ARF copy
flush_i  in  1  mispredict flush: invalidate all entries
valid_cnt_o  out  RRF_SEL+1  number of entries with valid=1

Behaviour:
- Storage: valid[RRF_NUM] and data[RRF_NUM][DATA_LEN], both updated on posedge clk_i.
- Reset (reset_i=1 at posedge): all valid←0 and all data←0. Reset overrides flush, alloc and wb.
- Reset outputs: valid_cnt_o=0; rd_data_o and com_data_o=0; rd_valid_o=0.
- While reset_i is high, rd_valid_o is forced to 0 combinationally.
- Writeback: for each k with wb_we_i[k]=1, data[tag]←wb_data and valid[tag]←1 at the next edge.
- Duplicate writeback tags in one cycle are a protocol error. They resolve deterministically: highest port index wins.
- Allocate: for each j with alloc_en_i[j]=1, valid[tag]←0. Data is unchanged.
- Allocate vs writeback on the same tag, same cycle: valid←0 (allocate wins). The data write from writeback still occurs.
- Flush: all valid←0 at the next edge. This overrides writeback and allocate valid updates. Writeback data writes still occur. Data array is otherwise untouched.
- Read ports are combinational, 0-cycle.
  - If any wb_we_i[k]=1 with wb_tag==rd_tag, the port returns wb_data with valid=1 (highest k wins).
  - Otherwise the port returns data[tag] and valid[tag].
  - Bypass is independent of alloc_en_i and flush_i in the same cycle.
- Commit ports are combinational with no bypass: com_data_o = data[com_tag]. COM only commits entries that were written in an earlier cycle.
- valid_cnt_o is the combinational popcount of the valid register, range 0..RRF_NUM.
- No storage flops outside the arrays; no internal FSM beyond the per-entry valid state machine. Per-entry valid transitions:
  - INVALID→VALID on writeback.
  - VALID→INVALID on alloc, flush or reset.
  - Alloc/flush has priority when it occurs together with writeback.
- Tags wrap naturally modulo RRF_NUM; the block does no free-list management.

Test Plan:
- Reset, then read tags 0..3 → rd_valid_o=0000, rd_data_o=0, valid_cnt_o=0.
- Cycle1: wb port0 tag 5 data 0xDEADBEEF → same cycle, rd port with tag 5 returns 0xDEADBEEF with valid=1 (bypass). Cycle2, no wb → array read gives the same; valid_cnt_o=1.
- wb port1 and port3 both tag 9 (0x11, 0x33) in one cycle → next cycle data[9]=0x33, valid=1, valid_cnt_o=1.
- Tag 9 valid; alloc tag 9 together with wb port0 tag 9 data 0x55 → next cycle valid[9]=0, data[9]=0x55, valid_cnt_o decrements by 1.
- Write tags 0..63 over successive cycles → valid_cnt_o=64. Then flush_i with wb tag 2 data 0x77 → next cycle valid_cnt_o=0 and com tag 2 returns 0x77.
- Tags 10,11 valid; reset_i asserted with wb tag 12 → rd_valid_o=0 during reset; next cycle all valid=0 and data[12]=0.
